// File: rtl/ram_dp_sync.sv
// Dual-port synchronous RAM with byte-masked writes and registered reads.
//
// Port 1 is read-only. Port 2 reads or writes, and its writes use a byte mask.
// Each accepted request gets a single-cycle valid pulse on the following cycle.
// When an address is out of range, the response has err set and data 0, and
// nothing is written. When CLEAR_ON_RESET is set, a clear engine zeroes every
// word after reset, and busy is high while it runs.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   busy              - clear engine running; requests are dropped
//   req1, a1          - port 1 read request and byte address
//   do1, valid1, err1 - port 1 read data, response strobe, out-of-range flag
//   req2, we2, a2     - port 2 request, write enable and byte address
//   di2, m2           - port 2 write data and byte mask
//   do2, valid2, err2 - port 2 read data, response/ack strobe, out-of-range flag
`timescale 1ns/1ps
module ram_dp_sync #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WORD_COUNT     = 128,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          WRITE_THROUGH  = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned BYTES         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] a1,
    output logic [DATA_WIDTH-1:0] do1,
    output logic                  valid1,
    output logic                  err1,
    input  logic                  req2,
    input  logic                  we2,
    input  logic [ADDR_WIDTH-1:0] a2,
    input  logic [DATA_WIDTH-1:0] di2,
    input  logic [BYTES-1:0]      m2,
    output logic [DATA_WIDTH-1:0] do2,
    output logic                  valid2,
    output logic                  err2
);

    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(WORD_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    logic [DATA_WIDTH-1:0] mem [WORD_COUNT];

    logic [ADDR_WIDTH-1:0] word1, word2;
    logic [IDX_W-1:0]      idx1, idx2;
    logic                  oor1, oor2;
    logic                  accept, rd1, acc2, rd2, wr2, clr_en;
    logic [DATA_WIDTH-1:0] rdata1;

    logic [DATA_WIDTH-1:0] do1_q, do2_q;
    logic                  valid1_q, valid2_q, err1_q, err2_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
    end

    // FSM: next state
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (reset) begin
            state_d   = CLEAR_ON_RESET ? StClear : StReady;
            clr_idx_d = '0;
        end else if (state_q == StClear) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = StReady;
            end
        end
    end

    assign busy   = (state_q == StClear);
    assign clr_en = (state_q == StClear) && !reset;

    // The full word number is compared against the depth, so an address past
    // the end is flagged instead of wrapping onto a real word.
    assign word1 = a1 >> LSB;
    assign word2 = a2 >> LSB;
    assign oor1  = (word1 >= ADDR_WIDTH'(WORD_COUNT));
    assign oor2  = (word2 >= ADDR_WIDTH'(WORD_COUNT));
    assign idx1  = a1[LSB +: IDX_W];
    assign idx2  = a2[LSB +: IDX_W];

    assign accept = !reset && (state_q == StReady);
    assign rd1    = accept && req1;
    assign acc2   = accept && req2;
    assign rd2    = acc2 && !we2;
    assign wr2    = acc2 && we2 && !oor2;

    // Port 1 read data. With write-through, the masked bytes of a same-word
    // port 2 write are forwarded; otherwise the old word is returned.
    always_comb begin
        rdata1 = mem[idx1];
        if (WRITE_THROUGH && wr2 && (idx1 == idx2)) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (m2[b]) begin
                    rdata1[8*b +: 8] = di2[8*b +: 8];
                end
            end
        end
    end

    // Array storage. It is never reset, and only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx_q] <= '0;
        end else if (wr2) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (m2[b]) begin
                    mem[idx2][8*b +: 8] <= di2[8*b +: 8];
                end
            end
        end
    end

    // Response registers. Data and err hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            do1_q    <= '0;
            do2_q    <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            err1_q   <= 1'b0;
            err2_q   <= 1'b0;
        end else begin
            valid1_q <= rd1;
            valid2_q <= acc2;
            if (rd1) begin
                err1_q <= oor1;
                do1_q  <= oor1 ? '0 : rdata1;
            end
            if (acc2) begin
                err2_q <= oor2;
            end
            // Write acks leave do2 untouched.
            if (rd2) begin
                do2_q <= oor2 ? '0 : mem[idx2];
            end
        end
    end

    assign do1    = do1_q;
    assign do2    = do2_q;
    assign valid1 = valid1_q;
    assign valid2 = valid2_q;
    assign err1   = err1_q;
    assign err2   = err2_q;

endmodule
